keypad_top: RTL and testbench

Top-level block for a 4x3 matrix-keypad two-digit entry unit: scans the keypad (or takes a direct key code in simulation), debounces key codes, runs a small entry FSM (digits, LOAD, CLEAR) and drives a 4-digit multiplexed seven-segment display. Module name `keypad_top`; it sits directly under the board wrapper.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_if.sv | 18 +
 rtl/key_debounce.sv | 51 +++++
 rtl/keypad_top.sv | 124 ++++++++++++
 tb/tb_keypad_top.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, entry FSM states and the seven-segment decoder.
package keypad_pkg;

    localparam logic [3:0] KEY_LOAD  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE       = 1'b0,
        ST_HAVE_DIGIT = 1'b1
    } kp_state_e;

    // Returns {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad rows/columns, direct test code and seven-segment display pins.
interface keypad_if;
    logic       A, B, C, D;
    logic       E, F, G;
    logic [3:0] test;
    logic       CA, CB, CC, CD, CE, CF, CG, DP;
    logic [3:0] AN;

    modport master (
        output A, B, C, D, CA, CB, CC, CD, CE, CF, CG, DP, AN,
        input  E, F, G, test
    );

    modport slave (
        input  A, B, C, D, CA, CB, CC, CD, CE, CF, CG, DP, AN,
        output E, F, G, test
    );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: accepts a key code after DEBOUNCE_CYCLES stable samples and pulses o_key_evt once per new press.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_raw,
    output logic [3:0] o_stable,
    output logic       o_key_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    r_prev;
    logic [3:0]    r_last;
    logic [CW-1:0] r_cnt;
    logic          w_accept;

    assign w_accept = (i_raw == r_prev) && (r_cnt == C_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev    <= KEY_NONE;
            r_cnt     <= '0;
        end else if (i_raw != r_prev) begin
            r_prev    <= i_raw;
            r_cnt     <= '0;
        end else if (r_cnt != C_MAX) begin
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    // A stable NONE rewrites r_last, so re-pressing the same key fires again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_stable  <= KEY_NONE;
            r_last    <= KEY_NONE;
            o_key_evt <= 1'b0;
        end else begin
            o_key_evt <= w_accept && (i_raw != KEY_NONE) && (i_raw != r_last);
            if (w_accept) begin
                o_stable <= i_raw;
                r_last   <= i_raw;
            end
        end
    end

endmodule

// File: rtl/keypad_top.sv
// keypad_top: 4x3 keypad scanner, debounced two-digit BCD entry FSM and 4-digit seven-segment mux.
// Define KEYPAD_SIM_KEY_EN to take key codes from kp.test instead of the scanner.
module keypad_top
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int REFRESH_DIV     = 1000
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    keypad_if.master kp
);

    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam logic [SW-1:0] SCAN_MAX    = SW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_HAVE = ST_HAVE_DIGIT;

    logic [1:0]    r_row;
    logic [SW-1:0] r_scan_cnt;
    logic [3:0]    r_raw;
    logic [0:0]    r_state;
    logic [3:0]    r_pend;
    logic [7:0]    r_value;
    logic [RW-1:0] r_ref_cnt;
    logic [1:0]    r_dig;

    logic [2:0]    w_hot;
    logic          w_any;
    logic          w_one;
    logic [1:0]    w_col;
    logic [3:0]    w_scan_code;
    logic [3:0]    w_raw_in;
    logic [3:0]    w_code;
    logic          w_evt;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic [6:0]    w_seg;

    // Columns are active-low returns; anything other than exactly one low is "no key".
    assign w_hot = ~{kp.G, kp.F, kp.E};
    assign w_any = |w_hot;
    assign w_one = (w_hot == 3'b001) || (w_hot == 3'b010) || (w_hot == 3'b100);
    assign w_col = w_hot[2] ? 2'd2 : w_hot[1] ? 2'd1 : 2'd0;

    assign w_scan_code = !w_one        ? KEY_NONE :
                         r_row == 2'd3 ? (w_col == 2'd0 ? KEY_LOAD : w_col == 2'd1 ? 4'h0 : KEY_CLEAR) :
                         {2'b00, r_row} * 4'd3 + {2'b00, w_col} + 4'd1;

    assign {kp.D, kp.C, kp.B, kp.A} = ~(4'b0001 << r_row);

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            r_row      <= '0;
            r_scan_cnt <= '0;
        end else if (!w_any) begin
            r_scan_cnt <= (r_scan_cnt == SCAN_MAX) ? '0 : r_scan_cnt + 1'b1;
            r_row      <= (r_scan_cnt == SCAN_MAX) ? r_row + 2'd1 : r_row;
        end
    end

`ifdef KEYPAD_SIM_KEY_EN
    assign w_raw_in = kp.test;
`else
    assign w_raw_in = w_scan_code;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) r_raw <= KEY_NONE;
        else           r_raw <= w_raw_in;
    end

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk       (sys_clk),
        .rst       (sys_rst_n),
        .i_raw     (r_raw),
        .o_stable  (w_code),
        .o_key_evt (w_evt)
    );

    // Codes C, D and E fall through every branch and are ignored.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_value <= '0;
        end else if (w_evt) begin
            if (w_code <= 4'd9) begin
                r_pend  <= w_code;
                r_state <= S_HAVE;
            end else if (w_code == KEY_CLEAR) begin
                r_value <= '0;
                r_pend  <= '0;
                r_state <= S_IDLE;
            end else if (w_code == KEY_LOAD && r_state == S_HAVE) begin
                r_value <= {r_value[3:0], r_pend};
                r_pend  <= '0;
                r_state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            r_ref_cnt <= '0;
            r_dig     <= '0;
        end else begin
            r_ref_cnt <= (r_ref_cnt == REFRESH_MAX) ? '0 : r_ref_cnt + 1'b1;
            r_dig     <= (r_ref_cnt == REFRESH_MAX) ? r_dig + 2'd1 : r_dig;
        end
    end

    assign w_nib   = r_dig == 2'd0 ? r_value[3:0] : r_dig == 2'd1 ? r_value[7:4] : r_pend;
    assign w_blank = (r_dig == 2'd2) || (r_dig == 2'd3 && r_state == S_IDLE);
    assign w_seg   = w_blank ? 7'h7F : seg7(w_nib);

    assign {kp.CG, kp.CF, kp.CE, kp.CD, kp.CC, kp.CB, kp.CA} = w_seg;
    assign kp.DP = 1'b1;
    assign kp.AN = ~(4'b0001 << r_dig);

endmodule

// File: tb/tb_keypad_top.sv
// tb_keypad_top: random key entry through a keypad model, checked on the multiplexed display.
module tb_keypad_top;

    localparam int DEB = 4;
    localparam int SDIV = 4;
    localparam int RDIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_val = 8'h00;
    logic [3:0] m_pend = 4'h0;
    bit         m_have = 1'b0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    keypad_if kp();

    keypad_top #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SDIV), .REFRESH_DIV(RDIV)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst),
        .kp        (kp)
    );

    always #5 clk = ~clk;

    // Physical keypad: the pressed key shorts its row to its column.
    function automatic logic pressed(input logic [3:0] k, input logic [3:0] rows_n, input int col);
        int r, c;
        if (k >= 4'd1 && k <= 4'd9) begin
            r = (int'(k) - 1) / 3;
            c = (int'(k) - 1) % 3;
        end else if (k == 4'h0) begin
            r = 3; c = 1;
        end else if (k == 4'hA) begin
            r = 3; c = 0;
        end else if (k == 4'hB) begin
            r = 3; c = 2;
        end else begin
            return 1'b0;
        end
        return rows_n[r] == 1'b0 && c == col;
    endfunction

    assign kp.E = ~pressed(key, {kp.D, kp.C, kp.B, kp.A}, 0);
    assign kp.F = ~pressed(key, {kp.D, kp.C, kp.B, kp.A}, 1);
    assign kp.G = ~pressed(key, {kp.D, kp.C, kp.B, kp.A}, 2);
    assign kp.test = key;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] k);
        if (k <= 4'd9) begin
            m_pend = k;
            m_have = 1'b1;
        end else if (k == 4'hB) begin
            m_val  = 8'h00;
            m_have = 1'b0;
        end else if (k == 4'hA && m_have) begin
            m_val  = {m_val[3:0], m_pend};
            m_have = 1'b0;
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int rel);
        @(negedge clk);
        key = k;
        repeat (hold) @(negedge clk);
        key = 4'hF;
        repeat (rel) @(negedge clk);
        model(k);
    endtask

    task automatic glitch(input logic [3:0] k);
        @(negedge clk);
        key = k;
        @(negedge clk);
        key = 4'hF;
        repeat (20) @(negedge clk);
    endtask

    task automatic check_display(input string tag);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] an_exp;
            logic [6:0] seg_exp;
            logic [3:0] nib;
            bit         blank;
            int         t;
            an_exp = ~(4'b0001 << d);
            nib    = d == 0 ? m_val[3:0] : d == 1 ? m_val[7:4] : m_pend;
            blank  = (d == 2) || (d == 3 && !m_have);
            seg_exp = blank ? 7'h7F : ~hex_tab[nib];
            t = 0;
            while (kp.AN !== an_exp && t < 64) begin
                @(negedge clk);
                t++;
            end
            check({tag, "_an"}, kp.AN, an_exp);
            check({tag, "_seg"}, {kp.CG, kp.CF, kp.CE, kp.CD, kp.CC, kp.CB, kp.CA}, seg_exp);
            check({tag, "_dp"}, kp.DP, 1'b1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rows", {kp.D, kp.C, kp.B, kp.A}, 4'b1110);
        check("rst_an", kp.AN, 4'b1110);
        check("rst_seg", {kp.CG, kp.CF, kp.CE, kp.CD, kp.CC, kp.CB, kp.CA}, 7'h40);
        rst = 1'b0;
        check_display("reset");

        // Bounced 3 then held: a single digit entry.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            key = (i % 2 == 0) ? 4'h3 : 4'hF;
        end
        press(4'h3, 50, 30);
        check_display("bounce3");
        press(4'hA, 50, 30);
        check_display("load3");
        press(4'h5, 50, 30);
        press(4'hA, 50, 30);
        check_display("load35");
        press(4'hB, 50, 30);
        check_display("clear");
        press(4'hA, 50, 30);
        check_display("load_idle");
        glitch(4'h7);
        check_display("glitch7");
        press(4'h2, 1000, 30);
        check_display("hold2");
        press(4'hA, 50, 30);
        press(4'hA, 50, 30);
        check_display("load_twice");
        press(4'h0, 50, 30);
        press(4'h0, 50, 30);
        press(4'h9, 50, 30);
        check_display("key9");

        press(4'hB, 50, 30);
        press(4'h3, 50, 30);
        press(4'hA, 50, 30);
        press(4'h5, 50, 30);
        press(4'hA, 50, 30);
        press(4'h9, 50, 30);
        check_display("pre_reset");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rows", {kp.D, kp.C, kp.B, kp.A}, 4'b1110);
        check("mid_rst_an", kp.AN, 4'b1110);
        check("mid_rst_seg", {kp.CG, kp.CF, kp.CE, kp.CD, kp.CC, kp.CB, kp.CA}, 7'h40);
        @(negedge clk);
        rst = 1'b0;
        m_val  = 8'h00;
        m_have = 1'b0;
        m_pend = 4'h0;
        check_display("post_reset");

        for (int i = 0; i < 60; i++) begin
            logic [3:0] k;
            k = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 7) == 0) glitch(k);
            else press(k, 40 + int'($urandom_range(0, 30)), 25 + int'($urandom_range(0, 15)));
            check_display("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
